hack_fetch: RTL

Instruction fetch stage for the Hack CPU. It holds the program counter and requests 16-bit instruction words from instruction memory over a req/ack handshake. Each fetched word is registered and presented to the decode stage with a valid/ready handshake. The stage consumes the jump decision and target from the execute side to form the next PC.

---
 rtl/hack_fetch_if.sv | 28 ++
 rtl/hack_fetch.sv | 101 ++++++++++
 2 files changed

// File: rtl/hack_fetch_if.sv
// Fetch-stage bus: instruction-memory req/ack port plus decode valid/ready port.
// master = fetch stage, slave = memory/decode environment.
interface hack_fetch_if #(
    parameter int unsigned ADDR_W = 15
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [15:0]       imem_rdata;
    logic [15:0]       instr;
    logic              instr_type;
    logic              instr_valid;
    logic              instr_ready;
    logic              jump;
    logic [15:0]       jump_addr;
    logic [ADDR_W-1:0] pc;
    logic              fault;

    modport master (
        output imem_req, imem_addr, instr, instr_type, instr_valid, pc, fault,
        input  imem_ack, imem_rdata, instr_ready, jump, jump_addr
    );

    modport slave (
        input  imem_req, imem_addr, instr, instr_type, instr_valid, pc, fault,
        output imem_ack, imem_rdata, instr_ready, jump, jump_addr
    );
endinterface

// File: rtl/hack_fetch.sv
// Hack CPU instruction fetch stage: PC, req/ack fetch from ROM, valid/ready issue to decode.
// Optional FETCH_TIMEOUT_EN: halt with sticky fault after TIMEOUT_CYCLES unacked fetch cycles.
module hack_fetch #(
    parameter int unsigned ADDR_W         = 15,
    parameter int unsigned RESET_VECTOR   = 0,
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic         clk,
    input  logic         reset,
    hack_fetch_if.master bus
);
    localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_VECTOR);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] pc_q;
    logic [15:0]       instr_q;
    logic              timeout_hit_c;

    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("hack_fetch: TIMEOUT_CYCLES must be nonzero");
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  state_d = FETCH;
            FETCH: begin
                if (bus.imem_ack)   state_d = ISSUE;
                else if (timeout_hit_c) state_d = HALT;
            end
            ISSUE: if (bus.instr_ready) state_d = FETCH;
            HALT:  state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    // PC and instruction registers; ack and ready only matter in their own states
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= RST_PC;
            instr_q <= 16'h0000;
        end else begin
            if (state_q == FETCH && bus.imem_ack)
                instr_q <= bus.imem_rdata;
            if (state_q == ISSUE && bus.instr_ready) begin
                if (bus.jump) pc_q <= bus.jump_addr[ADDR_W-1:0];
                else          pc_q <= pc_q + ADDR_W'(1);
            end
        end
    end

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt_q;
    logic             fault_q;

    // Counter is zero whenever FETCH is entered, counts unacked FETCH cycles
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt_q <= '0;
            fault_q    <= 1'b0;
        end else begin
            if (state_q != FETCH)   wait_cnt_q <= '0;
            else if (!bus.imem_ack) wait_cnt_q <= wait_cnt_q + CNT_W'(1);
            if (timeout_hit_c)      fault_q    <= 1'b1;
        end
    end

    // Last allowed cycle still accepts an ack
    assign timeout_hit_c = (state_q == FETCH) && !bus.imem_ack &&
                           (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign bus.fault     = fault_q;
`else
    assign timeout_hit_c = 1'b0;
    assign bus.fault     = 1'b0;
`endif

    assign bus.imem_req    = (state_q == FETCH);
    assign bus.instr_valid = (state_q == ISSUE);
    assign bus.imem_addr   = pc_q;
    assign bus.pc          = pc_q;
    assign bus.instr       = instr_q;
    assign bus.instr_type  = instr_q[15];

endmodule
